// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle spacing between rising edges of an asynchronous pulse
// and hands each period to a downstream consumer through a valid/ready slot.
`timescale 1ns/1ps
module pulse_period_meter #(
  parameter int N           = 32,
  parameter int TIMEOUT     = 100_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         pulse_in,
  output logic [N-1:0] period_out,
  output logic         period_valid,
  input  logic         period_ready,
  output logic         timeout,
  output logic         overrun
);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  localparam logic [N-1:0] TIMEOUT_CNT = N'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   pulse_edge;
  state_t                 state_q, state_d;
  logic [N-1:0]           cnt_q, cnt_d;
  logic                   res_vld;
  logic [N-1:0]           period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   overrun_q, overrun_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pulse_in};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  assign pulse_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Measurement FSM; en has priority over an edge arriving in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_vld   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = ARMED;
      end
      ARMED: begin
        cnt_d = '0;
        if (!en) begin
          state_d = IDLE;
        end else if (pulse_edge) begin
          state_d = MEASURE;
          cnt_d   = N'(1);
        end
      end
      MEASURE: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (pulse_edge) begin
          res_vld = 1'b1;
          cnt_d   = N'(1);
        end else if (cnt_q == TIMEOUT_CNT) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ARMED;
        end else begin
          cnt_d = cnt_q + N'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Single-entry result slot: a result landing on a full, unaccepted slot is dropped.
  always_comb begin
    period_d  = period_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (res_vld) begin
      if (!valid_q || period_ready) begin
        period_d = cnt_q;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && period_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: table of edge trains, hand sequences for slot and
// reset corners, and a random run checked cycle by cycle against a timestamp model.
`timescale 1ns/1ps
module tb_pulse_period_meter;
  localparam int N  = 32;
  localparam int TO = 1000;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst, en, pulse_in, period_ready;
  logic [N-1:0] period_out;
  logic         period_valid, timeout, overrun;

  always #5 clk = ~clk;

  pulse_period_meter #(.N(N), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
    .period_out(period_out), .period_valid(period_valid),
    .period_ready(period_ready), .timeout(timeout), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;

  // Reference model: edges found from the sampled pulse history, periods from timestamps.
  typedef enum int {M_IDLE, M_ARMED, M_MEAS} mmode_t;
  mmode_t       m_mode = M_IDLE;
  int           m_start = 0;
  bit           samp[SS+1];
  bit           m_valid = 0, m_to = 0, m_ovr = 0;
  logic [N-1:0] m_out = '0;
  int           got[$];
  int           to_cyc[$];

  typedef struct {
    int period;
    int n_edges;
    int exp_n;
    int exp_val;
    int exp_to;
  } row_t;
  row_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, k);
    end
  endtask

  task automatic model_step();
    bit e;
    bit res_ev;
    int res;
    res_ev = 0;
    res    = 0;
    if (rst) begin
      for (int i = 0; i <= SS; i++) samp[i] = 0;
      m_mode = M_IDLE; m_valid = 0; m_out = '0; m_to = 0; m_ovr = 0;
      return;
    end
    e = samp[SS-1] && !samp[SS];
    for (int i = SS; i > 0; i--) samp[i] = samp[i-1];
    samp[0] = pulse_in;
    m_to = 0;
    case (m_mode)
      M_IDLE:  if (en) m_mode = M_ARMED;
      M_ARMED: begin
        if (!en) m_mode = M_IDLE;
        else if (e) begin m_mode = M_MEAS; m_start = k; end
      end
      M_MEAS: begin
        if (!en) m_mode = M_IDLE;
        else if (e) begin res_ev = 1; res = k - m_start; m_start = k; end
        else if (k - m_start == TO) begin m_to = 1; m_mode = M_ARMED; end
      end
      default: m_mode = M_IDLE;
    endcase
    if (res_ev) begin
      if (!m_valid || period_ready) begin m_out = N'(res); m_valid = 1; end
      else m_ovr = 1;
    end else if (m_valid && period_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic tick();
    if (period_valid === 1'b1 && period_ready === 1'b1) got.push_back(int'(period_out));
    @(posedge clk);
    k++;
    model_step();
    #1;
    if (timeout === 1'b1) to_cyc.push_back(k);
    chk("cycle", {period_valid, timeout, overrun, period_out}, {m_valid, m_to, m_ovr, m_out});
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  // Rises spaced exactly `period` sample cycles apart, roughly 50% duty.
  task automatic edges(input int period, input int count);
    int hi;
    hi = (period / 2 > 0) ? period / 2 : 1;
    for (int c = 0; c < count; c++) begin
      pulse_in = 1'b1; cycles(hi);
      pulse_in = 1'b0; cycles(period - hi);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cycles(2); rst = 1'b0;
  endtask

  initial begin
    int j;
    int run;
    tbl[0] = '{400, 3, 2, 400, 0};
    tbl[1] = '{2, 4, 3, 2, 0};
    tbl[2] = '{TO, 3, 2, TO, 0};
    tbl[3] = '{TO + 1, 3, 0, 0, 2};
    tbl[4] = '{37, 5, 4, 37, 0};

    rst = 1'b1; en = 1'b0; pulse_in = 1'b0; period_ready = 1'b0;
    cycles(3);
    chk("rst_valid", period_valid, 0);
    chk("rst_out", period_out, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    cycles(2);

    for (int r = 0; r < 5; r++) begin
      en = 1'b0; period_ready = 1'b1; pulse_in = 1'b0;
      cycles(5);
      got.delete(); to_cyc.delete();
      en = 1'b1;
      edges(tbl[r].period, tbl[r].n_edges);
      cycles(1);
      en = 1'b0;
      cycles(5);
      chk("row_results", got.size(), tbl[r].exp_n);
      foreach (got[i]) chk("row_period", got[i], tbl[r].exp_val);
      chk("row_timeouts", to_cyc.size(), tbl[r].exp_to);
    end

    // Full slot, consumer stalled: second result dropped, overrun set.
    do_reset();
    en = 1'b1; period_ready = 1'b0;
    edges(50, 1); edges(70, 1);
    pulse_in = 1'b1; cycles(5); pulse_in = 1'b0;
    chk("stall_out", period_out, 50);
    chk("stall_valid", period_valid, 1);
    chk("stall_overrun", overrun, 1);
    period_ready = 1'b1; cycles(1); period_ready = 1'b0;
    chk("drain_valid", period_valid, 0);
    chk("drain_overrun_sticky", overrun, 1);

    // Timeout after a lone edge, then a fresh measurement.
    do_reset();
    en = 1'b1; period_ready = 1'b1; to_cyc.delete();
    j = k + 1;
    pulse_in = 1'b1; cycles(5); pulse_in = 1'b0;
    cycles(1100);
    chk("to_count", to_cyc.size(), 1);
    chk("to_cycle", (to_cyc.size() > 0) ? to_cyc[0] - j : -1, SS + TO);
    got.delete();
    edges(300, 1);
    pulse_in = 1'b1; cycles(5); pulse_in = 1'b0; cycles(5);
    chk("after_to_n", got.size(), 1);
    chk("after_to_val", (got.size() > 0) ? got[0] : -1, 300);

    // Accept and new result on the same posedge.
    do_reset();
    en = 1'b1; period_ready = 1'b0;
    edges(100, 2);
    pulse_in = 1'b1; cycles(2);
    period_ready = 1'b1; cycles(1); period_ready = 1'b0;
    chk("same_cyc_valid", period_valid, 1);
    chk("same_cyc_out", period_out, 100);
    chk("same_cyc_overrun", overrun, 0);
    pulse_in = 1'b0; cycles(3);

    // en dropped mid-measurement discards the partial interval.
    do_reset();
    en = 1'b1; period_ready = 1'b1; got.delete(); to_cyc.delete();
    pulse_in = 1'b1; cycles(5); pulse_in = 1'b0; cycles(17);
    en = 1'b0; cycles(5); en = 1'b1;
    edges(200, 1);
    pulse_in = 1'b1; cycles(5); pulse_in = 1'b0; cycles(5);
    chk("abort_n", got.size(), 1);
    chk("abort_val", (got.size() > 0) ? got[0] : -1, 200);
    chk("abort_to", to_cyc.size(), 0);

    // Reset mid-measurement with a full slot and overrun; pulse held high across it.
    do_reset();
    en = 1'b1; period_ready = 1'b0;
    edges(60, 3);
    pulse_in = 1'b1; cycles(5);
    chk("pre_rst_valid", period_valid, 1);
    chk("pre_rst_overrun", overrun, 1);
    rst = 1'b1; cycles(1);
    chk("mid_rst_valid", period_valid, 0);
    chk("mid_rst_out", period_out, 0);
    chk("mid_rst_overrun", overrun, 0);
    rst = 1'b0; en = 1'b0; cycles(6);
    en = 1'b1; got.delete(); to_cyc.delete();
    cycles(1100);
    chk("held_high_to", to_cyc.size(), 0);
    chk("held_high_valid", period_valid, 0);
    pulse_in = 1'b0; cycles(5);
    edges(150, 1);
    pulse_in = 1'b1; cycles(5); pulse_in = 1'b0;
    period_ready = 1'b1; cycles(3);
    chk("rearm_n", got.size(), 1);
    chk("rearm_val", (got.size() > 0) ? got[0] : -1, 150);

    // Random traffic against the model.
    do_reset();
    en = 1'b1; run = 1;
    for (int c = 0; c < 30000; c++) begin
      run--;
      if (run <= 0) begin
        pulse_in = ~pulse_in;
        case ($urandom_range(0, 9))
          0, 1, 2: run = $urandom_range(1, 4);
          3:       run = $urandom_range(900, 1200);
          default: run = $urandom_range(20, 600);
        endcase
      end
      period_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1999) == 0) en = ~en;
      rst = ($urandom_range(0, 4999) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
